bp_fe_ftq: RTL and testbench
============================

BP_FE_FTQ -- requirements
Module: bp_fe_ftq

Interface

Parameters (name, default, meaning):
- REQ-001 The block SHALL have parameter vaddr_width_p, default 39: virtual address width.
- REQ-002 The block SHALL have parameter els_p, default 8: queue depth, a power of two and at least 2.
- REQ-003 The block SHALL have parameter fetch_bytes_p, default 4: fetch block size in bytes, a power of two.
- REQ-004 The block SHALL have parameter md_width_p, default 32: width of the opaque branch-metadata payload.

Ports (name, direction, width, meaning):
- REQ-005 The block SHALL have the following ports.
  - clk_i  in  1  the only clock.
  - reset_i  in  1  synchronous, active-high reset.
  - reset_pc_i  in  vaddr_width_p  PC loaded during reset.
  - pred_pc_o  out  vaddr_width_p  current generation PC, driven to the predictor.
  - pred_taken_i  in  1  predictor says the block at pred_pc_o is taken (same cycle).
  - pred_tgt_i  in  vaddr_width_p  predicted target.
  - pred_md_i  in  md_width_p  metadata for the block at pred_pc_o.
  - fetch_v_o  out  1  entry available to fetch.
  - fetch_pc_o  out  vaddr_width_p  PC of that entry.
  - fetch_taken_o  out  1  taken bit of that entry.
  - fetch_md_o  out  md_width_p  metadata of that entry.
  - fetch_yumi_i  in  1  fetch consumes the entry.
  - retire_i  in  1  oldest fetched entry is complete.
  - replay_i  in  1  rewind fetch to the oldest unretired entry.
  - redirect_v_i  in  1  flush the queue and restart.
  - redirect_npc_i  in  vaddr_width_p  restart PC.
  - full_o, empty_o  out  1  occupancy flags.
  - count_o  out  $clog2(els_p)+1  entries between commit and enqueue.

Function
- REQ-006 The block SHALL keep three pointers of $clog2(els_p)+1 bits each (index plus wrap bit): enq_r, fetch_r, commit_r.
- REQ-007 Storage SHALL be els_p entries of {pc, taken, md}, implemented as registers or a 1R1W RAM with asynchronous read.
- REQ-008 count_o SHALL equal enq_r-commit_r modulo the pointer width.
- REQ-009 full_o SHALL be (count_o==els_p); empty_o SHALL be (enq_r==commit_r); both SHALL be derived from registered state only.
- REQ-010 Generation PC register gen_pc_r SHALL drive pred_pc_o combinationally.
- REQ-011 Enqueue SHALL occur when ~full_o & ~redirect_v_i & ~reset_i.
- REQ-012 On enqueue, the entry at enq_r SHALL be written with {gen_pc_r, pred_taken_i, pred_md_i}, and enq_r SHALL increment.
- REQ-013 On enqueue, gen_pc_r SHALL be set to pred_tgt_i if pred_taken_i, else to (gen_pc_r with its low log2(fetch_bytes_p) bits cleared)+fetch_bytes_p.
- REQ-014 The gen_pc_r increment SHALL wrap modulo 2^vaddr_width_p.
- REQ-015 When enqueue is blocked by full_o, gen_pc_r SHALL hold, and pred_* SHALL be ignored that cycle.
- REQ-016 fetch_v_o SHALL be (fetch_r!=enq_r); fetch_pc_o, fetch_taken_o and fetch_md_o SHALL be the entry at fetch_r.
- REQ-017 When fetch_v_o=0, the fetch_* data outputs SHALL be don't-care.
- REQ-018 fetch_yumi_i SHALL advance fetch_r by one, and SHALL only be asserted when fetch_v_o=1.
- REQ-019 retire_i SHALL advance commit_r by one, and SHALL only be asserted when commit_r!=fetch_r.
- REQ-020 replay_i SHALL set fetch_r to commit_r as updated by a same-cycle retire_i.
- REQ-021 When replay_i is asserted, a same-cycle fetch_yumi_i SHALL be ignored.
- REQ-022 replay_i SHALL not affect enq_r or gen_pc_r.
- REQ-023 redirect_v_i SHALL set enq_r, fetch_r and commit_r to 0 and gen_pc_r to redirect_npc_i.
- REQ-024 When redirect_v_i is asserted, any same-cycle enqueue, fetch_yumi_i, retire_i or replay_i SHALL be ignored.
- REQ-025 Priority SHALL be reset_i > redirect_v_i > replay_i > {retire_i, fetch_yumi_i, enqueue}.
- REQ-026 Retire and enqueue in the same cycle while full SHALL not enqueue; the slot becomes usable the next cycle.
- REQ-027 All state updates SHALL occur on the rising edge of clk_i; there SHALL be no combinational path from fetch_yumi_i, retire_i or replay_i to any output.
- REQ-028 Pointer wrap SHALL be by natural overflow of the pointer width; no other wrap logic is permitted.

Reset
- REQ-029 While reset_i=1, enq_r, fetch_r and commit_r SHALL be 0 and gen_pc_r SHALL load reset_pc_i.
- REQ-030 During reset, empty_o SHALL read 1, full_o 0, count_o 0, and fetch_v_o 0.
- REQ-031 During reset, pred_pc_o SHALL equal reset_pc_i from the first post-reset cycle, and no enqueue SHALL occur.
- REQ-032 Assertion of reset_i mid-operation SHALL discard all entries within one cycle.
- REQ-033 Entry storage contents need not be reset.

Verification (els_p=4, fetch_bytes_p=4, reset_pc_i=0x80000000)
- REQ-034 Linear fill, no fetch, pred_taken_i=0 -> entries 0x80000000, 0x80000004, 0x80000008, 0x8000000C; full_o=1 after 4 cycles; pred_pc_o then holds at 0x80000010.
- REQ-035 Taken prediction at 0x80000004 with pred_tgt_i=0x80001000 -> next entry pc=0x80001000 and the previous entry has fetch_taken_o=1.
- REQ-036 Fetch 3 entries, retire 1, then replay_i -> fetch_pc_o=0x80000004, count_o=3.
- REQ-037 redirect_v_i=1 with replay_i, fetch_yumi_i and retire_i all asserted, redirect_npc_i=0x80002002 -> empty next cycle; next enqueued pc=0x80002002; following pc=0x80002004 (aligned step).
- REQ-038 When full, retire_i with pred valid -> no enqueue that cycle; count_o=3 then 4 on the following cycle.
- REQ-039 reset_i asserted mid-stream with 3 entries -> fetch_v_o=0 and count_o=0 next cycle; pred_pc_o=reset_pc_i.

Source files
------------

// File: rtl/bp_fe_ftq.sv
// Fetch target queue: generates sequential/predicted PCs, buffers them with
// branch metadata, and tracks enqueue / fetch / commit positions for replay.
module bp_fe_ftq #(
  parameter int vaddr_width_p = 39,
  parameter int els_p         = 8,
  parameter int fetch_bytes_p = 4,
  parameter int md_width_p    = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [vaddr_width_p-1:0]  reset_pc_i,
  output logic [vaddr_width_p-1:0]  pred_pc_o,
  input  logic                      pred_taken_i,
  input  logic [vaddr_width_p-1:0]  pred_tgt_i,
  input  logic [md_width_p-1:0]     pred_md_i,
  output logic                      fetch_v_o,
  output logic [vaddr_width_p-1:0]  fetch_pc_o,
  output logic                      fetch_taken_o,
  output logic [md_width_p-1:0]     fetch_md_o,
  input  logic                      fetch_yumi_i,
  input  logic                      retire_i,
  input  logic                      replay_i,
  input  logic                      redirect_v_i,
  input  logic [vaddr_width_p-1:0]  redirect_npc_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(els_p):0]    count_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;
  localparam logic [vaddr_width_p-1:0] fb_mask_lp = vaddr_width_p'(fetch_bytes_p - 1);
  localparam logic [vaddr_width_p-1:0] fb_step_lp = vaddr_width_p'(fetch_bytes_p);

  logic [ptr_w_lp-1:0]      enq_r, fetch_r, commit_r, commit_n;
  logic [vaddr_width_p-1:0] gen_pc_r, gen_pc_n;
  logic                     enq_v;

  logic [vaddr_width_p-1:0] pc_mem    [els_p];
  logic                     taken_mem [els_p];
  logic [md_width_p-1:0]    md_mem    [els_p];

  // Flags come only from registered pointers, so no input reaches them.
  assign count_o   = enq_r - commit_r;
  assign full_o    = (count_o == ptr_w_lp'(els_p));
  assign empty_o   = (enq_r == commit_r);
  assign enq_v     = ~full_o & ~redirect_v_i & ~reset_i;
  assign pred_pc_o = gen_pc_r;

  // Fall-through steps from the aligned block base; wraps by natural overflow.
  assign gen_pc_n  = pred_taken_i ? pred_tgt_i : ((gen_pc_r & ~fb_mask_lp) + fb_step_lp);
  assign commit_n  = commit_r + ptr_w_lp'(retire_i);

  assign fetch_v_o     = (fetch_r != enq_r);
  assign fetch_pc_o    = pc_mem[fetch_r[lg_els_lp-1:0]];
  assign fetch_taken_o = taken_mem[fetch_r[lg_els_lp-1:0]];
  assign fetch_md_o    = md_mem[fetch_r[lg_els_lp-1:0]];

  always_ff @(posedge clk_i) begin
    if (enq_v) begin
      pc_mem[enq_r[lg_els_lp-1:0]]    <= gen_pc_r;
      taken_mem[enq_r[lg_els_lp-1:0]] <= pred_taken_i;
      md_mem[enq_r[lg_els_lp-1:0]]    <= pred_md_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      enq_r    <= '0;
      fetch_r  <= '0;
      commit_r <= '0;
      gen_pc_r <= reset_pc_i;
    end else if (redirect_v_i) begin
      enq_r    <= '0;
      fetch_r  <= '0;
      commit_r <= '0;
      gen_pc_r <= redirect_npc_i;
    end else begin
      if (enq_v) begin
        enq_r    <= enq_r + 1'b1;
        gen_pc_r <= gen_pc_n;
      end
      commit_r <= commit_n;
      // Replay rewinds to the commit point including this cycle's retire.
      if (replay_i)
        fetch_r <= commit_n;
      else if (fetch_yumi_i)
        fetch_r <= fetch_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_fe_ftq.sv
// Bench for bp_fe_ftq with els_p=4: directed scenarios plus a random
// stream checked against a queue-based reference of expected entries.
module tb_bp_fe_ftq;

  localparam int VA = 39;
  localparam int MD = 32;
  localparam logic [VA-1:0] RESET_PC = 39'h0_8000_0000;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [VA-1:0] reset_pc_i = RESET_PC;
  logic [VA-1:0] pred_pc_o;
  logic          pred_taken_i = 1'b0;
  logic [VA-1:0] pred_tgt_i = '0;
  logic [MD-1:0] pred_md_i = '0;
  logic          fetch_v_o;
  logic [VA-1:0] fetch_pc_o;
  logic          fetch_taken_o;
  logic [MD-1:0] fetch_md_o;
  logic          fetch_yumi_i = 1'b0;
  logic          retire_i = 1'b0;
  logic          replay_i = 1'b0;
  logic          redirect_v_i = 1'b0;
  logic [VA-1:0] redirect_npc_i = '0;
  logic          full_o, empty_o;
  logic [2:0]    count_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [VA-1:0] pc;
    logic          taken;
    logic [MD-1:0] md;
  } ent_t;

  ent_t          exp_q[$];
  int            fidx = 0;
  logic [VA-1:0] mgen = RESET_PC;

  always #5 clk = ~clk;

  bp_fe_ftq #(.vaddr_width_p(VA), .els_p(4), .fetch_bytes_p(4), .md_width_p(MD)) dut (
    .clk_i(clk), .reset_i(reset_i), .reset_pc_i(reset_pc_i), .pred_pc_o(pred_pc_o),
    .pred_taken_i(pred_taken_i), .pred_tgt_i(pred_tgt_i), .pred_md_i(pred_md_i),
    .fetch_v_o(fetch_v_o), .fetch_pc_o(fetch_pc_o), .fetch_taken_o(fetch_taken_o),
    .fetch_md_o(fetch_md_o), .fetch_yumi_i(fetch_yumi_i), .retire_i(retire_i),
    .replay_i(replay_i), .redirect_v_i(redirect_v_i), .redirect_npc_i(redirect_npc_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
  );

  // Applies one cycle of stimulus, updates the reference queue, advances a clock.
  task automatic drive(input bit rst, input bit taken, input logic [VA-1:0] tgt,
                       input logic [MD-1:0] md, input bit yumi, input bit retire,
                       input bit replay, input bit redir, input logic [VA-1:0] npc);
    bit   enq;
    ent_t e;
    reset_i = rst; pred_taken_i = taken; pred_tgt_i = tgt; pred_md_i = md;
    fetch_yumi_i = yumi; retire_i = retire; replay_i = replay;
    redirect_v_i = redir; redirect_npc_i = npc;
    if (rst) begin
      exp_q.delete(); fidx = 0; mgen = RESET_PC;
    end else if (redir) begin
      exp_q.delete(); fidx = 0; mgen = npc;
    end else begin
      enq = (exp_q.size() < 4);
      e.pc = mgen; e.taken = taken; e.md = md;
      if (retire) begin
        void'(exp_q.pop_front());
        fidx--;
      end
      if (replay) fidx = 0;
      else if (yumi) fidx++;
      if (enq) begin
        exp_q.push_back(e);
        mgen = taken ? tgt : ((mgen & ~39'h3) + 39'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 39'h1234, 0, 1, 1, 1, 0, 0);
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    vectors++; if (full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", full_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    vectors++; if (fetch_v_o !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_v got=%b exp=0", fetch_v_o); end
    vectors++; if (pred_pc_o !== RESET_PC) begin miscompares++; $display("FAIL reset_pred_pc got=%h exp=%h", pred_pc_o, RESET_PC); end
  endtask

  task automatic test_linear_fill();
    logic [VA-1:0] want;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, MD'(i), 0, 0, 0, 0, 0);
    vectors++; if (full_o !== 1'b1) begin miscompares++; $display("FAIL fill_full got=%b exp=1", full_o); end
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL fill_count got=%0d exp=4", count_o); end
    vectors++; if (pred_pc_o !== 39'h0_8000_0010) begin miscompares++; $display("FAIL fill_pred_pc got=%h exp=8000_0010", pred_pc_o); end
    drive(0, 1, 39'h1234_5678, 32'hdead, 0, 0, 0, 0, 0);
    vectors++; if (pred_pc_o !== 39'h0_8000_0010) begin miscompares++; $display("FAIL fill_hold_pc got=%h exp=8000_0010", pred_pc_o); end
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL fill_hold_count got=%0d exp=4", count_o); end
    for (int i = 0; i < 4; i++) begin
      want = RESET_PC + VA'(4 * i);
      vectors++; if (fetch_pc_o !== want) begin miscompares++; $display("FAIL fill_entry_pc[%0d] got=%h exp=%h", i, fetch_pc_o, want); end
      vectors++; if (fetch_md_o !== exp_q[fidx].md) begin miscompares++; $display("FAIL fill_entry_md[%0d] got=%h exp=%h", i, fetch_md_o, exp_q[fidx].md); end
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    vectors++; if (fetch_v_o !== 1'b0) begin miscompares++; $display("FAIL fill_drained_v got=%b exp=0", fetch_v_o); end
  endtask

  task automatic test_taken();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'd0, 0, 0, 0, 0, 0);
    drive(0, 1, 39'h0_8000_1000, 32'd1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'd2, 0, 0, 0, 0, 0);
    vectors++; if (pred_pc_o !== 39'h0_8000_1004) begin miscompares++; $display("FAIL taken_pred_pc got=%h exp=8000_1004", pred_pc_o); end
    vectors++; if (fetch_taken_o !== 1'b0) begin miscompares++; $display("FAIL taken_e0_taken got=%b exp=0", fetch_taken_o); end
    drive(0, 0, 0, 32'd3, 1, 0, 0, 0, 0);
    vectors++; if (fetch_pc_o !== 39'h0_8000_0004) begin miscompares++; $display("FAIL taken_e1_pc got=%h exp=8000_0004", fetch_pc_o); end
    vectors++; if (fetch_taken_o !== 1'b1) begin miscompares++; $display("FAIL taken_e1_taken got=%b exp=1", fetch_taken_o); end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    vectors++; if (fetch_pc_o !== 39'h0_8000_1000) begin miscompares++; $display("FAIL taken_e2_pc got=%h exp=8000_1000", fetch_pc_o); end
    vectors++; if (fetch_md_o !== 32'd2) begin miscompares++; $display("FAIL taken_e2_md got=%h exp=2", fetch_md_o); end
  endtask

  task automatic test_pc_wrap();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 39'h7F_FFFF_FFFE, 0, 0, 0, 0, 0, 0);
    vectors++; if (pred_pc_o !== 39'h7F_FFFF_FFFE) begin miscompares++; $display("FAIL wrap_tgt got=%h exp=7f_ffff_fffe", pred_pc_o); end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    vectors++; if (pred_pc_o !== 39'h0) begin miscompares++; $display("FAIL wrap_pc got=%h exp=0", pred_pc_o); end
    vectors++; if (fetch_pc_o !== 39'h7F_FFFF_FFFE) begin miscompares++; $display("FAIL wrap_entry got=%h exp=7f_ffff_fffe", fetch_pc_o); end
  endtask

  task automatic test_replay();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    vectors++; if (fetch_pc_o !== 39'h0_8000_000C) begin miscompares++; $display("FAIL replay_pre_pc got=%h exp=8000_000c", fetch_pc_o); end
    drive(0, 0, 0, 0, 1, 1, 1, 0, 0);
    vectors++; if (fetch_pc_o !== 39'h0_8000_0004) begin miscompares++; $display("FAIL replay_pc got=%h exp=8000_0004", fetch_pc_o); end
    vectors++; if (count_o !== 3'd3) begin miscompares++; $display("FAIL replay_count got=%0d exp=3", count_o); end
    vectors++; if (pred_pc_o !== 39'h0_8000_0010) begin miscompares++; $display("FAIL replay_pred_pc got=%h exp=8000_0010", pred_pc_o); end
  endtask

  task automatic test_full_retire();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    vectors++; if (count_o !== 3'd3) begin miscompares++; $display("FAIL full_retire_count got=%0d exp=3", count_o); end
    vectors++; if (pred_pc_o !== 39'h0_8000_0010) begin miscompares++; $display("FAIL full_retire_pc got=%h exp=8000_0010", pred_pc_o); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL full_refill_count got=%0d exp=4", count_o); end
    vectors++; if (full_o !== 1'b1) begin miscompares++; $display("FAIL full_refill_full got=%b exp=1", full_o); end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 39'h55_0000, 32'h7, 1, 1, 1, 1, 39'h0_8000_2002);
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL redir_empty got=%b exp=1", empty_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL redir_count got=%0d exp=0", count_o); end
    vectors++; if (fetch_v_o !== 1'b0) begin miscompares++; $display("FAIL redir_fetch_v got=%b exp=0", fetch_v_o); end
    vectors++; if (pred_pc_o !== 39'h0_8000_2002) begin miscompares++; $display("FAIL redir_pred_pc got=%h exp=8000_2002", pred_pc_o); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++; if (fetch_pc_o !== 39'h0_8000_2002) begin miscompares++; $display("FAIL redir_e0 got=%h exp=8000_2002", fetch_pc_o); end
    vectors++; if (pred_pc_o !== 39'h0_8000_2004) begin miscompares++; $display("FAIL redir_step got=%h exp=8000_2004", pred_pc_o); end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    vectors++; if (fetch_pc_o !== 39'h0_8000_2004) begin miscompares++; $display("FAIL redir_e1 got=%h exp=8000_2004", fetch_pc_o); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++; if (count_o !== 3'd3) begin miscompares++; $display("FAIL rmid_pre_count got=%0d exp=3", count_o); end
    drive(1, 1, 39'h4444, 0, 1, 0, 0, 0, 0);
    vectors++; if (fetch_v_o !== 1'b0) begin miscompares++; $display("FAIL rmid_fetch_v got=%b exp=0", fetch_v_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL rmid_count got=%0d exp=0", count_o); end
    vectors++; if (pred_pc_o !== RESET_PC) begin miscompares++; $display("FAIL rmid_pred_pc got=%h exp=%h", pred_pc_o, RESET_PC); end
  endtask

  task automatic test_back_to_back();
    bit            tk, yu, rt, rp, rd;
    logic [VA-1:0] tgt;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 300; c++) begin
      vectors++; if (count_o !== 3'(exp_q.size())) begin miscompares++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", c, count_o, exp_q.size()); end
      vectors++; if (pred_pc_o !== mgen) begin miscompares++; $display("FAIL b2b_pred_pc[%0d] got=%h exp=%h", c, pred_pc_o, mgen); end
      vectors++; if (fetch_v_o !== (fidx < exp_q.size())) begin miscompares++; $display("FAIL b2b_fetch_v[%0d] got=%b exp=%b", c, fetch_v_o, fidx < exp_q.size()); end
      if (fidx < exp_q.size()) begin
        vectors++; if ({fetch_pc_o, fetch_taken_o, fetch_md_o} !== exp_q[fidx]) begin
          miscompares++;
          $display("FAIL b2b_entry[%0d] got=%h/%b/%h exp=%h/%b/%h", c, fetch_pc_o, fetch_taken_o,
                   fetch_md_o, exp_q[fidx].pc, exp_q[fidx].taken, exp_q[fidx].md);
        end
      end
      tk  = ($urandom_range(3) == 0);
      tgt = {$urandom(), $urandom()};
      tgt = tgt & ~39'h3;
      yu  = (fidx < exp_q.size()) && ($urandom_range(2) != 0);
      rt  = (fidx > 0) && ($urandom_range(2) != 0);
      rp  = ($urandom_range(15) == 0);
      rd  = ($urandom_range(49) == 0);
      drive(0, tk, tgt, $urandom(), yu, rt, rp, rd, {$urandom(), $urandom()});
    end
  endtask

  initial begin
    test_reset();
    test_linear_fill();
    test_taken();
    test_pc_wrap();
    test_replay();
    test_full_retire();
    test_redirect();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
